// File: rtl/program_store_if.sv
// Host load byte link between the deframer and the program store.
interface program_store_if;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;

  modport master (output ld_data, output ld_valid, input ld_ready);
  modport slave  (input ld_data, input ld_valid, output ld_ready);
endinterface

// File: rtl/program_store.sv
// Writable program/delay RAM for the glitch sequencer, loaded by framed host bytes.
// Latency: reads registered, 1 cycle. Backpressure: ld_ready drops while run_active; frame FSM holds.
module program_store #(
  parameter int INSTR_W    = 12,
  parameter int PROG_DEPTH = 256,
  parameter int DELAY_W    = 32,
  parameter int NUM_DELAYS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  program_store_if.slave     ld,
  input  logic               run_active,
  input  logic [7:0]         instr_pt,
  input  logic [7:0]         delay_num,
  output logic [INSTR_W-1:0] instr,
  output logic [DELAY_W-1:0] delay_len,
  output logic [8:0]         prog_len,
  output logic               busy,
  output logic               err
);

  localparam int PAW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int DAW = (NUM_DELAYS > 1) ? $clog2(NUM_DELAYS) : 1;
  localparam logic [9:0] PROG_LIM = 10'(PROG_DEPTH);
  localparam logic [9:0] DLY_LIM  = 10'(NUM_DELAYS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IDX   = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state;
  logic        is_prog;
  logic [7:0]  idx;
  logic [7:0]  cnt;
  logic [7:0]  k;
  logic [1:0]  bcnt;
  logic [23:0] asm_q;
  logic        ready_q;
  logic [2**DAW-1:0] dvalid;

  logic [INSTR_W-1:0] pram [2**PAW];
  logic [DELAY_W-1:0] dram [2**DAW];

  logic        accept;
  logic        last_byte;
  logic        last_entry;
  logic        wr_en;
  logic [9:0]  span;
  logic [9:0]  limit;
  logic [8:0]  waddr;
  logic [8:0]  waddr_p1;
  logic [15:0] pword;
  logic [31:0] dword;

  assign ld.ld_ready = ready_q & ~run_active;
  assign busy        = (state != S_IDLE);

  assign accept     = ld.ld_valid & ld.ld_ready;
  assign last_byte  = is_prog ? (bcnt == 2'd1) : (bcnt == 2'd3);
  assign last_entry = (({1'b0, k} + 9'd1) == {1'b0, cnt});
  assign span       = {2'b00, idx} + {2'b00, ld.ld_data};
  assign limit      = is_prog ? PROG_LIM : DLY_LIM;
  assign waddr      = {1'b0, idx} + {1'b0, k};
  assign waddr_p1   = waddr + 9'd1;
  assign wr_en      = (state == S_DATA) && accept && last_byte;
  assign pword      = {ld.ld_data, asm_q[7:0]};
  assign dword      = {ld.ld_data, asm_q};

  // Upper word bits beyond the configured widths are intentionally dropped.
  wire unused_ok = &{1'b0, pword, dword, waddr};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (is_prog) pram[waddr[PAW-1:0]] <= pword[INSTR_W-1:0];
      else         dram[waddr[DAW-1:0]] <= dword[DELAY_W-1:0];
    end
  end

  // Gating uses pre-write prog_len/dvalid, so a same-cycle write reads old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr     <= '0;
      delay_len <= '0;
    end else begin
      instr     <= ({1'b0, instr_pt} < prog_len) ? pram[instr_pt[PAW-1:0]] : '0;
      delay_len <= (({2'b00, delay_num} < DLY_LIM) && dvalid[delay_num[DAW-1:0]])
                   ? dram[delay_num[DAW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_prog  <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      k        <= '0;
      bcnt     <= '0;
      asm_q    <= '0;
      err      <= 1'b0;
      prog_len <= '0;
      dvalid   <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        case (state)
          S_IDLE: begin
            case (ld.ld_data)
              8'h01: begin is_prog <= 1'b1; state <= S_IDX; end
              8'h02: begin is_prog <= 1'b0; state <= S_IDX; end
              8'h03: begin prog_len <= '0; dvalid <= '0; err <= 1'b0; end
              default: err <= 1'b1;
            endcase
          end
          S_IDX: begin
            idx   <= ld.ld_data;
            state <= S_CNT;
          end
          S_CNT: begin
            cnt  <= ld.ld_data;
            k    <= '0;
            bcnt <= '0;
            if (ld.ld_data == 8'd0) begin
              state <= S_IDLE;
            end else if (span > limit) begin
              err   <= 1'b1;
              state <= S_DRAIN;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA, S_DRAIN: begin
            if (last_byte) begin
              bcnt <= '0;
              k    <= k + 8'd1;
              if (last_entry) state <= S_IDLE;
              if (state == S_DATA) begin
                if (is_prog && (waddr_p1 > prog_len)) prog_len <= waddr_p1;
                if (!is_prog) dvalid[waddr[DAW-1:0]] <= 1'b1;
              end
            end else begin
              bcnt <= bcnt + 2'd1;
              case (bcnt)
                2'd0:    asm_q[7:0]   <= ld.ld_data;
                2'd1:    asm_q[15:8]  <= ld.ld_data;
                2'd2:    asm_q[23:16] <= ld.ld_data;
                default: ;
              endcase
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store (PROG_DEPTH=16, NUM_DELAYS=16).
module tb_program_store;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_active = 1'b0;
  logic [7:0]  instr_pt = 8'd0;
  logic [7:0]  delay_num = 8'd0;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic [8:0]  prog_len;
  logic        busy;
  logic        err;
  int          errors = 0;
  int          checks = 0;

  program_store_if lif ();

  program_store #(.INSTR_W(12), .PROG_DEPTH(16), .DELAY_W(32), .NUM_DELAYS(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld(lif), .run_active(run_active),
    .instr_pt(instr_pt), .delay_num(delay_num), .instr(instr),
    .delay_len(delay_len), .prog_len(prog_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    lif.ld_data = b;
    lif.ld_valid = 1'b1;
    while (!lif.ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1 lif.ld_valid = 1'b0;
  endtask

  task automatic rd_instr(input string tag, input logic [7:0] pt, input logic [11:0] exp);
    @(negedge clk);
    instr_pt = pt;
    @(negedge clk);
    chk(tag, {20'd0, instr}, {20'd0, exp});
  endtask

  task automatic rd_delay(input string tag, input logic [7:0] dn, input logic [31:0] exp);
    @(negedge clk);
    delay_num = dn;
    @(negedge clk);
    chk(tag, delay_len, exp);
  endtask

  initial begin
    lif.ld_data = 8'h00;
    lif.ld_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("rst_ld_ready_low", {31'd0, lif.ld_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // 1: reset state
    chk("rst_instr", {20'd0, instr}, 32'd0);
    chk("rst_delay", delay_len, 32'd0);
    chk("rst_prog_len", {23'd0, prog_len}, 32'd0);
    chk("rst_ld_ready", {31'd0, lif.ld_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 2: two program entries
    send(8'h01); send(8'h00); send(8'h02);
    send(8'h84); send(8'h08); send(8'h01);
    chk("p_busy_mid", {31'd0, busy}, 32'd1);
    send(8'h00);
    chk("p_prog_len", {23'd0, prog_len}, 32'd2);
    chk("p_busy_end", {31'd0, busy}, 32'd0);
    rd_instr("p_pt0", 8'd0, 12'h884);
    rd_instr("p_pt1", 8'd1, 12'h001);
    rd_instr("p_pt2", 8'd2, 12'h000);

    // 3: delay entries, including the last table slot
    send(8'h02); send(8'h03); send(8'h01);
    send(8'hA0); send(8'hEA); send(8'h02); send(8'h04);
    rd_delay("d_num3", 8'd3, 32'h0402EAA0);
    rd_delay("d_num2", 8'd2, 32'h0);
    send(8'h02); send(8'h0F); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    rd_delay("d_num15", 8'd15, 32'h44332211);
    rd_delay("d_num31_oob", 8'd31, 32'h0);

    // 4: overflowing frame drains, exact-fit frame loads
    send(8'h01); send(8'h0F); send(8'h02);
    chk("ovf_err", {31'd0, err}, 32'd1);
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("ovf_drain_busy", {31'd0, busy}, 32'd1);
    send(8'hDD);
    chk("ovf_drain_done", {31'd0, busy}, 32'd0);
    chk("ovf_prog_len", {23'd0, prog_len}, 32'd2);
    send(8'h01); send(8'h0F); send(8'h01); send(8'h34); send(8'h12);
    chk("fit_prog_len", {23'd0, prog_len}, 32'd16);
    rd_instr("fit_pt15", 8'd15, 12'h234);
    send(8'h01); send(8'h05); send(8'h00);
    chk("cnt0_busy", {31'd0, busy}, 32'd0);
    chk("cnt0_prog_len", {23'd0, prog_len}, 32'd16);
    send(8'h03);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_prog_len", {23'd0, prog_len}, 32'd0);
    rd_instr("clr_pt0", 8'd0, 12'h000);
    rd_delay("clr_num3", 8'd3, 32'h0);
    send(8'h07);
    chk("badcmd_err", {31'd0, err}, 32'd1);
    chk("badcmd_busy", {31'd0, busy}, 32'd0);
    send(8'h03);
    chk("clr2_err", {31'd0, err}, 32'd0);

    // 5: run_active stalls a frame after IDX
    send(8'h01); send(8'h04);
    @(negedge clk);
    run_active = 1'b1;
    lif.ld_data = 8'h01;
    lif.ld_valid = 1'b1;
    #1 chk("run_ld_ready", {31'd0, lif.ld_ready}, 32'd0);
    repeat (5) @(negedge clk);
    chk("run_hold_busy", {31'd0, busy}, 32'd1);
    chk("run_hold_len", {23'd0, prog_len}, 32'd0);
    lif.ld_valid = 1'b0;
    run_active = 1'b0;
    send(8'h01); send(8'h56); send(8'h07);
    chk("run_prog_len", {23'd0, prog_len}, 32'd5);
    rd_instr("run_pt4", 8'd4, 12'h756);
    rd_instr("run_pt0_kept", 8'd0, 12'h884);

    // read-before-write on slot 4
    @(negedge clk);
    instr_pt = 8'd4;
    send(8'h01); send(8'h04); send(8'h01); send(8'hAB); send(8'h0C);
    chk("rbw_old", {20'd0, instr}, {20'd0, 12'h756});
    @(posedge clk);
    #1 chk("rbw_new", {20'd0, instr}, {20'd0, 12'hCAB});

    // 6: reset mid-DATA
    send(8'h01); send(8'h08); send(8'h01); send(8'hEF);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_len", {23'd0, prog_len}, 32'd0);
    rd_instr("mid_rst_pt8", 8'd8, 12'h000);
    rd_instr("mid_rst_pt4", 8'd4, 12'h000);
    rd_delay("mid_rst_num3", 8'd3, 32'h0);
    send(8'h01); send(8'h08); send(8'h01); send(8'h21); send(8'h03);
    chk("reload_len", {23'd0, prog_len}, 32'd9);
    rd_instr("reload_pt8", 8'd8, 12'h321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
